// File: rtl/seg7_scan_decoder.sv
// Recovers hex nibbles from a multiplexed active-low 7-segment bus (shared segments, per-digit anodes).
// Optional decimal-point capture is enabled by defining SEG7_SCAN_DEC_DP_EN.
module seg7_scan_decoder #(
    parameter int N_DIGITS      = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_DIGITS-1:0]   an_in,
    input  logic [6:0]            seg_in,
`ifdef SEG7_SCAN_DEC_DP_EN
    input  logic                  dp_in,
    output logic [N_DIGITS-1:0]   dp_out,
`endif
    output logic [4*N_DIGITS-1:0] hex_out,
    output logic [N_DIGITS-1:0]   digit_valid,
    output logic [N_DIGITS-1:0]   pattern_err,
    output logic                  update,
    output logic                  frame_done
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } state_t;

    // Returns {legal, nibble}; legal=0 for any code outside the hex font.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0010000: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [N_DIGITS-1:0]   an_q, an_prev_q;
    logic [6:0]            seg_q, seg_prev_q;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [N_DIGITS-1:0]   seen_q, seen_d;
    logic [4*N_DIGITS-1:0] hex_q, hex_d;
    logic [N_DIGITS-1:0]   valid_q, valid_d;
    logic [N_DIGITS-1:0]   err_q, err_d;
    logic                  update_q, update_d;
    logic                  frame_q, frame_d;

    logic                  sel_ok;
    logic [IDX_W-1:0]      sel_idx;
    logic                  changed;
    logic                  commit;
    logic [4:0]            dec;
    logic [N_DIGITS-1:0]   seen_next;

`ifdef SEG7_SCAN_DEC_DP_EN
    logic                  dp_q, dp_prev_q;
    logic [N_DIGITS-1:0]   dp_out_q, dp_out_d;
`endif

    // Input capture stage plus a one-deep history used for the stability compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q       <= '1;
            seg_q      <= '1;
            an_prev_q  <= '1;
            seg_prev_q <= '1;
        end else begin
            an_q       <= an_in;
            seg_q      <= seg_in;
            an_prev_q  <= an_q;
            seg_prev_q <= seg_q;
        end
    end

`ifdef SEG7_SCAN_DEC_DP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_q      <= 1'b1;
            dp_prev_q <= 1'b1;
        end else begin
            dp_q      <= dp_in;
            dp_prev_q <= dp_q;
        end
    end
`endif

    always_comb begin
        sel_ok  = $onehot(~an_q);
        sel_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!an_q[i]) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        changed = (an_q != an_prev_q) || (seg_q != seg_prev_q);
`ifdef SEG7_SCAN_DEC_DP_EN
        changed = changed || (dp_q != dp_prev_q);
`endif
    end

    // Commit fires on the edge that completes the window, so cnt and outputs land together.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sel_ok) begin
                    state_d = TRACK;
                    cnt_d   = CNT_W'(1);
                end
            end
            TRACK: begin
                if (!sel_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    cnt_d = CNT_W'(1);
                end else if (cnt_q >= CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = HELD;
                    cnt_d   = CNT_W'(STABLE_CYCLES);
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sel_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    state_d = TRACK;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        hex_d     = hex_q;
        valid_d   = valid_q;
        err_d     = err_q;
        seen_d    = seen_q;
        update_d  = 1'b0;
        frame_d   = 1'b0;
        dec       = seg_decode(seg_q);
        seen_next = seen_q | (N_DIGITS'(1) << sel_idx);
`ifdef SEG7_SCAN_DEC_DP_EN
        dp_out_d  = dp_out_q;
`endif
        if (commit) begin
            update_d = 1'b1;
            if (dec[4]) begin
                hex_d[4*sel_idx +: 4] = dec[3:0];
                valid_d[sel_idx]      = 1'b1;
                err_d[sel_idx]        = 1'b0;
            end else begin
                valid_d[sel_idx]      = 1'b0;
                err_d[sel_idx]        = 1'b1;
            end
`ifdef SEG7_SCAN_DEC_DP_EN
            dp_out_d[sel_idx] = ~dp_q;
`endif
            // A full mask closes the frame and restarts collection in the same cycle.
            if (&seen_next) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d  = seen_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            seen_q   <= '0;
            hex_q    <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            update_q <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            hex_q    <= hex_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            update_q <= update_d;
            frame_q  <= frame_d;
        end
    end

`ifdef SEG7_SCAN_DEC_DP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_out_q <= '0;
        end else begin
            dp_out_q <= dp_out_d;
        end
    end

    assign dp_out = dp_out_q;
`endif

    assign hex_out     = hex_q;
    assign digit_valid = valid_q;
    assign pattern_err = err_q;
    assign update      = update_q;
    assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: commit latency, glitch rejection, illegal codes,
// full-frame scan, multi-select rejection and mid-window reset.
module tb_seg7_scan_decoder;

    localparam int N = 8;
    localparam int SC = 4;

    localparam logic [6:0] C1 = 7'b1111001;
    localparam logic [6:0] C2 = 7'b0100100;
    localparam logic [6:0] C3 = 7'b0110000;
    localparam logic [6:0] C4 = 7'b0011001;
    localparam logic [6:0] C5 = 7'b0010010;
    localparam logic [6:0] C6 = 7'b0000010;
    localparam logic [6:0] C7 = 7'b1111000;
    localparam logic [6:0] C8 = 7'b0000000;
    localparam logic [6:0] C9 = 7'b0010000;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   an_in;
    logic [6:0]     seg_in;
    logic [4*N-1:0] hex_out;
    logic [N-1:0]   digit_valid;
    logic [N-1:0]   pattern_err;
    logic           update;
    logic           frame_done;
`ifdef SEG7_SCAN_DEC_DP_EN
    logic           dp_in = 1'b1;
    logic [N-1:0]   dp_out;
`endif

    seg7_scan_decoder #(
        .N_DIGITS      (N),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .an_in       (an_in),
        .seg_in      (seg_in),
`ifdef SEG7_SCAN_DEC_DP_EN
        .dp_in       (dp_in),
        .dp_out      (dp_out),
`endif
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .pattern_err (pattern_err),
        .update      (update),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   upd_cnt = 0;
    int   last_upd_cyc = 0;
    int   frm_cnt = 0;
    int   frm_cyc = -1;
    logic frm_with_upd = 1'b0;

    always @(negedge clk) begin
        if (update === 1'b1) begin
            upd_cnt      <= upd_cnt + 1;
            last_upd_cyc <= cyc;
        end
        if (frame_done === 1'b1) begin
            frm_cnt      <= frm_cnt + 1;
            frm_cyc      <= cyc;
            frm_with_upd <= update;
        end
    end

    int n_checks = 0;
    int n_fails  = 0;
    int t_start  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one bus value and let n rising edges pass; returns just after a falling edge.
    task automatic hold(input logic [N-1:0] a, input logic [6:0] s, input int n);
        an_in   = a;
        seg_in  = s;
        t_start = cyc;
        repeat (n) @(negedge clk);
        #2;
    endtask

    int u0, f0, r_cyc;
    logic [4*N-1:0] hex_snap;
    logic [N-1:0]   val_snap, err_snap;
    logic [6:0]     codes [N];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        codes[0] = C1; codes[1] = C2; codes[2] = C3; codes[3] = C4;
        codes[4] = C5; codes[5] = C6; codes[6] = C7; codes[7] = C8;
        an_in  = '1;
        seg_in = BLANK;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check_eq("rst_hex",   hex_out,     32'h0);
        check_eq("rst_valid", digit_valid, 32'h0);
        check_eq("rst_err",   pattern_err, 32'h0);
        check_eq("rst_upd",   update,      32'h0);
        check_eq("rst_frame", frame_done,  32'h0);
        reset = 1'b0;
        hold('1, BLANK, 2);

        // Single stable digit 2 on position 0.
        u0 = upd_cnt;
        hold(8'hFE, C2, 10);
        check_eq("t1_hex0",    hex_out[3:0],     32'h2);
        check_eq("t1_valid0",  digit_valid[0],   32'h1);
        check_eq("t1_err0",    pattern_err[0],   32'h0);
        check_eq("t1_nupd",    upd_cnt - u0,     32'd1);
        check_eq("t1_latency", last_upd_cyc - t_start, 32'd5);

        // Short-lived 3 is rejected, following 4 commits after its own window.
        u0 = upd_cnt;
        hold(8'hFE, C3, 3);
        check_eq("t2_nupd_3",  upd_cnt - u0,     32'd0);
        u0 = upd_cnt;
        hold(8'hFE, C4, 10);
        check_eq("t2_nupd_4",  upd_cnt - u0,     32'd1);
        check_eq("t2_latency", last_upd_cyc - t_start, 32'd5);
        check_eq("t2_hex0",    hex_out[3:0],     32'h4);

        // Digit 3 shows 9, then blank: flagged illegal, nibble retained.
        hold(8'hF7, C9, 6);
        check_eq("t3_hex3_9",  hex_out[15:12],   32'h9);
        check_eq("t3_valid3a", digit_valid[3],   32'h1);
        hold(8'hF7, BLANK, 6);
        check_eq("t3_err3",    pattern_err[3],   32'h1);
        check_eq("t3_valid3b", digit_valid[3],   32'h0);
        check_eq("t3_hex3",    hex_out[15:12],   32'h9);
        check_eq("t3_hex0",    hex_out[3:0],     32'h4);

        // Full scan of all digits after a clean reset.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        u0 = upd_cnt;
        f0 = frm_cnt;
        for (int i = 0; i < N; i++) begin
            hold(8'hFF ^ (8'h01 << i), codes[i], 6);
        end
        check_eq("t4_hex",     hex_out,          32'h87654321);
        check_eq("t4_valid",   digit_valid,      32'hFF);
        check_eq("t4_err",     pattern_err,      32'h0);
        check_eq("t4_nupd",    upd_cnt - u0,     32'd8);
        check_eq("t4_nframe",  frm_cnt - f0,     32'd1);
        check_eq("t4_frm_upd", frm_with_upd,     32'h1);
        check_eq("t4_frm_cyc", frm_cyc,          last_upd_cyc);

        // Two anodes low: no selection, nothing changes.
        hex_snap = hex_out;
        val_snap = digit_valid;
        err_snap = pattern_err;
        u0 = upd_cnt;
        f0 = frm_cnt;
        hold(8'hFC, C5, 10);
        check_eq("t5_nupd",    upd_cnt - u0,     32'd0);
        check_eq("t5_nframe",  frm_cnt - f0,     32'd0);
        check_eq("t5_hex",     hex_out,          hex_snap);
        check_eq("t5_valid",   digit_valid,      val_snap);
        check_eq("t5_err",     pattern_err,      err_snap);

        // Reset lands inside a stable window; a fresh full window is needed afterwards.
        hold(8'hFE, C5, 2);
        reset = 1'b1;
        @(negedge clk);
        #2;
        r_cyc = cyc;
        u0 = upd_cnt;
        check_eq("t6_rst_hex",   hex_out,     32'h0);
        check_eq("t6_rst_valid", digit_valid, 32'h0);
        check_eq("t6_rst_err",   pattern_err, 32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        check_eq("t6_early",   upd_cnt - u0,     32'd0);
        @(negedge clk);
        #2;
        check_eq("t6_nupd",    upd_cnt - u0,     32'd1);
        check_eq("t6_latency", last_upd_cyc - r_cyc, 32'd5);
        check_eq("t6_hex",     hex_out,          32'h5);
        check_eq("t6_valid",   digit_valid,      32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
